// File: rtl/time_set_sequencer.sv
// time_set_sequencer: collects a "T"+HHMMSS frame, runs the ASCII-to-BCD converter, range-checks and loads the time
//   clk, init (async active-low reset)
//   rx_data/rx_valid          : received byte stream
//   conv_ascii/conv_start/conv_clear_n, conv_done/conv_bcd : converter handshake
//   time_bcd/time_load        : validated time and its one-cycle load strobe
//   busy, error, err_code     : status (err_code 01 bad char, 10 timeout, 11 out of range)
module time_set_sequencer #(
  parameter logic [7:0] START_CHAR     = 8'h54,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        init,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [47:0] conv_ascii,
  output logic        conv_start,
  output logic        conv_clear_n,
  input  logic        conv_done,
  input  logic [23:0] conv_bcd,
  output logic [23:0] time_bcd,
  output logic        time_load,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code
);
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CLEAR, S_START, S_WAIT, S_CHECK, S_LOAD} state_t;
  // WAIT gives up on the cycle its count steps onto TIMEOUT_CYCLES-1
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 2);
  state_t      state_q, state_d;
  logic [47:0] ascii_q, ascii_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [23:0] time_q, time_d;
  logic        load_q, load_d, err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        is_digit, bcd_ok;
  assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign bcd_ok = conv_bcd[23:20] <= 4'd2 &&
                  conv_bcd[19:16] <= ((conv_bcd[23:20] == 4'd2) ? 4'd3 : 4'd9) &&
                  conv_bcd[15:12] <= 4'd5 && conv_bcd[11:8] <= 4'd9 &&
                  conv_bcd[7:4] <= 4'd5 && conv_bcd[3:0] <= 4'd9;
  always_comb begin
    state_d = state_q;
    ascii_d = ascii_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    time_d  = time_q;
    load_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: if (rx_valid && rx_data == START_CHAR) begin
        state_d = S_COLLECT;
        cnt_d   = 3'd0;
        err_d   = 1'b0;
        code_d  = 2'b00;
      end
      S_COLLECT: if (cnt_q == 3'd6) state_d = S_CLEAR;
      else if (rx_valid) begin
        if (is_digit) begin
          ascii_d[8*cnt_q +: 8] = rx_data;
          cnt_d = cnt_q + 3'd1;
        end else begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_START;
      S_START: begin
        tmo_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        if (conv_done) state_d = S_CHECK;
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = S_IDLE;
        end
      end
      S_CHECK: if (bcd_ok) state_d = S_LOAD;
      else begin
        err_d   = 1'b1;
        code_d  = 2'b11;
        state_d = S_IDLE;
      end
      S_LOAD: begin
        time_d  = conv_bcd;
        load_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state_q <= S_IDLE;
      ascii_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      time_q  <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ascii_q <= ascii_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      time_q  <= time_d;
      load_q  <= load_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end
  assign conv_ascii   = ascii_q;
  assign conv_start   = state_q == S_START || state_q == S_WAIT;
  // init feeds through so the converter is cleared the moment reset asserts
  assign conv_clear_n = init && state_q != S_CLEAR;
  assign time_bcd     = time_q;
  assign time_load    = load_q;
  assign busy         = state_q != S_IDLE;
  assign error        = err_q;
  assign err_code     = code_q;
endmodule

// File: tb/tb_time_set_sequencer.sv
// tb_time_set_sequencer: scoreboard bench with a converter model and a frame-level reference model
module tb_time_set_sequencer;
  localparam int TMO = 64;
  logic        clk = 1'b0;
  logic        init = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [47:0] conv_ascii;
  logic        conv_start, conv_clear_n, conv_done, time_load, busy, error;
  logic [23:0] conv_bcd, time_bcd;
  logic [1:0]  err_code;

  time_set_sequencer #(.START_CHAR(8'h54), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .init(init), .rx_data(rx_data), .rx_valid(rx_valid),
    .conv_ascii(conv_ascii), .conv_start(conv_start), .conv_clear_n(conv_clear_n),
    .conv_done(conv_done), .conv_bcd(conv_bcd), .time_bcd(time_bcd),
    .time_load(time_load), .busy(busy), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // converter model: done after lat cycles of conv_start (lat==0: never); result is the digit values
  int          lat = 1;
  int          ccnt = 0;
  bit          frc = 1'b0;
  logic [23:0] fv = '0;
  always @(posedge clk or negedge conv_clear_n) begin
    if (!conv_clear_n) begin
      conv_done <= 1'b0;
      ccnt <= 0;
    end else if (conv_start && !conv_done && lat != 0) begin
      ccnt <= ccnt + 1;
      if (ccnt + 1 == lat) conv_done <= 1'b1;
    end
  end
  always_comb begin
    conv_bcd = '0;
    for (int i = 0; i < 6; i++) conv_bcd[20-4*i +: 4] = conv_ascii[8*i +: 4];
    if (frc) conv_bcd = fv;
  end

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [23:0] tbcd;
    logic [47:0] ascii;
    int          cyc;
    int          run;
  } exp_t;
  exp_t exp_q[$];

  // monitor: an outcome is a time_load pulse or a rising error flag
  int st_run = 0;
  int last_run = 0;
  bit err_prev = 1'b0;
  always @(negedge clk) begin
    if (!init) begin
      st_run = 0;
      err_prev = 1'b0;
    end else begin
      if (conv_start) st_run++;
      else begin
        if (st_run != 0) last_run = st_run;
        st_run = 0;
      end
      if (time_load && error) begin
        tests++;
        fails++;
        $display("FAIL load_and_error: both high at cycle %0d", cyc);
      end
      if (time_load || (error && !err_prev)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: load=%0b error=%0b code=%0b at cycle %0d", time_load, error, err_code, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("error", error, e.is_err);
          chk("err_code", err_code, e.code);
          chk("time_bcd", time_bcd, e.tbcd);
          chk("conv_ascii", conv_ascii, e.ascii);
          chk("event_cycle", cyc, e.cyc);
          chk("busy_at_event", busy, 0);
          if (e.run >= 0) chk("conv_start_cycles", last_run, e.run);
        end
      end
      err_prev = error;
    end
  end

  // reference model state
  logic [47:0] ascii_m = '0;
  logic [23:0] time_m = '0;
  logic [7:0]  fr [7];

  function automatic bit time_ok(input logic [23:0] b);
    for (int i = 0; i < 6; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return (int'(b[23:20]) * 10 + int'(b[19:16]) < 24) && b[15:12] < 4'd6 && b[7:4] < 4'd6;
  endfunction

  task automatic send(input logic [7:0] b, output int n);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("outcome_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_frame(input int len);
    exp_t e;
    int n;
    bit bad = 1'b0;
    logic [23:0] bcd;
    send(fr[0], n);
    for (int i = 1; i < len; i++) begin
      send(fr[i], n);
      if (fr[i] >= 8'h30 && fr[i] <= 8'h39) ascii_m[8*(i-1) +: 8] = fr[i];
      else bad = 1'b1;
    end
    e.is_err = 1'b1;
    e.code = 2'b01;
    e.cyc = n;
    e.run = -1;
    if (!bad) begin
      bcd = frc ? fv : {fr[1][3:0], fr[2][3:0], fr[3][3:0], fr[4][3:0], fr[5][3:0], fr[6][3:0]};
      e.run = (lat == 0) ? TMO : lat + 1;
      if (lat == 0) begin
        e.code = 2'b10;
        e.cyc = n + 2 + TMO;
      end else if (time_ok(bcd)) begin
        e.is_err = 1'b0;
        e.code = 2'b00;
        time_m = bcd;
        e.cyc = n + 5 + lat;
      end else begin
        e.code = 2'b11;
        e.cyc = n + 4 + lat;
      end
    end
    e.tbcd = time_m;
    e.ascii = ascii_m;
    exp_q.push_back(e);
    drain();
  endtask

  task automatic set_frame(input logic [47:0] s);
    fr[0] = 8'h54;
    for (int i = 1; i < 7; i++) fr[i] = s[48-8*i +: 8];
  endtask

  initial begin
    int n;
    int d[6];
    int h, m, s;
    repeat (3) @(negedge clk);
    chk("rst_conv_ascii", conv_ascii, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_conv_clear_n", conv_clear_n, 0);
    chk("rst_time_bcd", time_bcd, 0);
    chk("rst_time_load", time_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    init = 1'b1;
    @(negedge clk);
    chk("post_rst_clear_n", conv_clear_n, 1);
    chk("post_rst_busy", busy, 0);

    lat = 3; set_frame("123456"); do_frame(7);
    chk("ascii_123456", conv_ascii, 48'h363534333231);
    set_frame("2359A0"); do_frame(6);
    lat = 2; set_frame("000000"); do_frame(7);
    lat = 0; set_frame("123456"); do_frame(7);
    lat = 4; set_frame("245960"); do_frame(7);
    set_frame("235959"); do_frame(7);
    chk("time_235959", time_bcd, 24'h235959);
    lat = 2; frc = 1'b1; fv = 24'h12A456; set_frame("111111"); do_frame(7);
    frc = 1'b0; lat = 1; set_frame("12T000"); do_frame(4);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        d = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
      end else begin
        d[0] = $urandom_range(0, 3);
        for (int i = 1; i < 6; i++) d[i] = $urandom_range(0, 9);
      end
      fr[0] = 8'h54;
      for (int i = 1; i < 7; i++) fr[i] = 8'(8'h30 + d[i-1]);
      lat = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 6);
      frc = ($urandom_range(0, 7) == 0);
      fv = 24'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(1, 6);
        fr[n] = 8'($urandom_range(8'h3A, 8'hFF));
        do_frame(n + 1);
      end else do_frame(7);
    end
    frc = 1'b0;

    lat = 0;
    set_frame("010203");
    for (int i = 0; i < 7; i++) send(fr[i], n);
    repeat (10) @(negedge clk);
    #2 init = 1'b0;
    #1;
    chk("abort_conv_start", conv_start, 0);
    chk("abort_conv_clear_n", conv_clear_n, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    init = 1'b1;
    send(8'h31, n);
    send(8'h41, n);
    @(negedge clk);
    chk("post_abort_busy", busy, 0);
    chk("post_abort_ascii", conv_ascii, 0);
    chk("post_abort_error", error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
